pc_ras: RTL
===========

# pc_ras

Parametrised program-counter unit for the fetch stage: it holds the fetch PC and advances it by one instruction per cycle unless stalled. It accepts three redirect kinds (jump, call, return), and keeps a circular return-address stack (RAS) so that returns redirect without a computed target. It sits at the front of the pipeline and feeds instruction memory. It takes redirects from decode/execute.

## Interface
- DBITS, 32, PC and address width
- INSTSIZE, 4, bytes per instruction; PC increment
- STARTPC, 32'h60, PC value loaded on reset
- RASDEPTH, 8, return-stack entries; power of two, >= 2
- CBITS, $clog2(RASDEPTH+1), width of RASCOUNT (derived; not overridden)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous active-low reset
- STALL  in  1  hold PC; blocks only the sequential increment
- JMP  in  1  redirect PC to PCIN
- CALL  in  1  push return address, redirect PC to PCIN
- RET  in  1  pop RAS, redirect PC to popped address
- FLUSH  in  1  empty the RAS (pointer/count only)
- PCIN  in  DBITS  redirect target for JMP/CALL; fallback target for RET on empty stack
- PCOUT  out  DBITS  current fetch PC (registered)
- RASCOUNT  out  CBITS  valid entries, 0..RASDEPTH
- RASEMPTY  out  1  RASCOUNT == 0
- RASFULL  out  1  RASCOUNT == RASDEPTH
- RASOVF  out  1  one-cycle pulse: push overwrote oldest entry
- RETMISS  out  1  one-cycle pulse: RET serviced with empty stack

## Operation
- Reset (RESET_N low, any time, asynchronous): PCOUT=STARTPC, top pointer=0, RASCOUNT=0, RASOVF=0, RETMISS=0. RAS storage is not cleared. Deassertion is synchronised externally.
- Per cycle, exactly one action is taken. Priority is RET > CALL > JMP > increment. Lower-priority redirects asserted in the same cycle are ignored.
- RET, RASCOUNT>0: PC <= entry[top-1]; top decrements mod RASDEPTH; RASCOUNT decrements.
- RET, RASCOUNT==0: PC <= PCIN; RETMISS pulses; stack unchanged.
- CALL: entry[top] <= PCOUT+INSTSIZE; top increments mod RASDEPTH; PC <= PCIN.
  - If RASCOUNT<RASDEPTH, RASCOUNT increments.
  - If the stack is full, the oldest entry is overwritten, RASCOUNT stays RASDEPTH, and RASOVF pulses.
- JMP: PC <= PCIN.
- Otherwise: if STALL=0, PC <= PCOUT+INSTSIZE; if STALL=1, PC holds.
- Redirects are honoured while STALL=1.
- FLUSH: top<=0 and RASCOUNT<=0. It is applied after any push/pop in the same cycle, so FLUSH wins over stack effects. The PC update from the same cycle's action still occurs: a CALL with FLUSH redirects the PC but leaves the stack empty, and a RET with FLUSH and a non-empty stack still uses the popped address.
- Arithmetic: PC addition is modulo 2^DBITS, so PC wraps from all-ones to 0 silently. No alignment checking.
- PCIN is sampled only in cycles where it is used.

## Timing
- Every output is registered; there is no combinational path from input to output.
- Redirect or increment is visible on PCOUT one cycle after the sampling edge.
- RASCOUNT, RASEMPTY and RASFULL reflect the post-edge state.
- RASOVF and RETMISS are high for exactly the one cycle following the causing edge.
- Back-to-back CALL/RET on consecutive cycles is fully supported, with no bubbles. A RET in cycle n+1 returns the address pushed in cycle n.
- Reset assertion mid-operation forces reset values immediately (asynchronously), without waiting for CLK.

## Test plan
- Reset then free-run, STALL=0, no redirects, 4 cycles -> PCOUT 0x60, 0x64, 0x68, 0x6C, 0x70; RASEMPTY=1.
- PC=0x80, STALL=1 for 3 cycles, then JMP with PCIN=0x200 while STALL=1 -> PC holds 0x80 for 3 cycles, then 0x200.
- PC=0x100, CALL with PCIN=0x400 -> PCOUT=0x400 and RASCOUNT=1. Next cycle RET -> PCOUT=0x104 and RASEMPTY=1.
- 9 CALLs with RASDEPTH=8 -> RASOVF pulses on the 9th only; RASCOUNT=8. Then 8 RETs return the last 8 return addresses in LIFO order. A 9th RET with PCIN=0x300 -> PCOUT=0x300 and RETMISS pulses.
- RET+CALL+JMP asserted together with RASCOUNT=2 -> only the pop occurs; RASCOUNT=1; PCOUT = popped address.
- PCOUT=0xFFFFFFFC, increment -> 0x00000000.
- RESET_N pulsed low between clock edges mid-sequence -> PCOUT=0x60 and RASCOUNT=0 before the next edge.

Source files
------------

// File: rtl/pc_ras.sv
// pc_ras: fetch program counter with jump/call/return redirects and a
// circular return-address stack that overwrites its oldest entry when full.
module pc_ras #(
  parameter int unsigned          DBITS    = 32,
  parameter int unsigned          INSTSIZE = 4,
  parameter logic [DBITS-1:0]     STARTPC  = DBITS'(32'h60),
  parameter int unsigned          RASDEPTH = 8,
  localparam int unsigned         CBITS    = $clog2(RASDEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             STALL,
  input  logic             JMP,
  input  logic             CALL,
  input  logic             RET,
  input  logic             FLUSH,
  input  logic [DBITS-1:0] PCIN,
  output logic [DBITS-1:0] PCOUT,
  output logic [CBITS-1:0] RASCOUNT,
  output logic             RASEMPTY,
  output logic             RASFULL,
  output logic             RASOVF,
  output logic             RETMISS
);

  localparam int unsigned PTRW = $clog2(RASDEPTH);

  logic [DBITS-1:0] pc_q, pc_d;
  logic [PTRW-1:0]  top_q, top_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             miss_q, miss_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             push;
  logic [DBITS-1:0] pc_inc;
  logic [DBITS-1:0] ras_q [RASDEPTH];

  assign pc_inc = pc_q + DBITS'(INSTSIZE);

  // Next-state: one prioritised action per cycle, then FLUSH overrides stack state
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    miss_d  = 1'b0;
    push    = 1'b0;

    if (RET) begin
      if (count_q != '0) begin
        pc_d    = ras_q[top_q - PTRW'(1)];
        top_d   = top_q - PTRW'(1);
        count_d = count_q - CBITS'(1);
      end else begin
        pc_d   = PCIN;
        miss_d = 1'b1;
      end
    end else if (CALL) begin
      push  = 1'b1;
      top_d = top_q + PTRW'(1);
      pc_d  = PCIN;
      if (count_q == CBITS'(RASDEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CBITS'(1);
      end
    end else if (JMP) begin
      pc_d = PCIN;
    end else if (!STALL) begin
      pc_d = pc_inc;
    end

    if (FLUSH) begin
      top_d   = '0;
      count_d = '0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CBITS'(RASDEPTH));
  end

  // Control and PC state, asynchronously reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q    <= STARTPC;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      miss_q  <= miss_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Return-address storage; contents survive reset and flush
  always_ff @(posedge CLK) begin
    if (push) begin
      ras_q[top_q] <= pc_inc;
    end
  end

  assign PCOUT    = pc_q;
  assign RASCOUNT = count_q;
  assign RASEMPTY = empty_q;
  assign RASFULL  = full_q;
  assign RASOVF   = ovf_q;
  assign RETMISS  = miss_q;

endmodule
